// File: rtl/acc_pkg.sv
// Shared constants and state encoding for the accelerator loader and its bridge.
// Window addresses must match the bridge's decode.
package acc_pkg;

    localparam int MAT_BYTES = 1024;
    localparam int IDX_W     = $clog2(MAT_BYTES);

    localparam logic [31:0] START_ADDR = 32'd1023;
    localparam logic [31:0] BASE_A     = 32'd1024;
    localparam logic [31:0] BASE_B     = 32'd2048;
    localparam logic [31:0] BASE_C     = 32'd3072;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_READ_C,
        S_DRAIN
    } acc_ld_state_t;

    function automatic logic [31:0] win_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base + {{(32 - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/acc_byte_fifo.sv
// Two-entry byte FIFO buffering result bytes between bridge reads and the output stream.
// A push is accepted while full if a pop happens in the same cycle.
module acc_byte_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic [1:0] count,
    output logic       empty
);

    logic [7:0] mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign empty    = (count == 2'd0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= 8'h00;
            mem[1] <= 8'h00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/acc_loader.sv
// Bus initiator that streams matrices A and B into the accelerator bridge, starts it,
// waits for done and streams matrix C back out.
module acc_loader
    import acc_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        acc_done,
    output logic        busy,
    output logic        error,
    output logic [2:0]  state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_MAX  = TW'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAT_BYTES - 1);

    acc_ld_state_t    state;
    logic [IDX_W-1:0] idx;
    logic [TW-1:0]    to_cnt;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic             err_q;
    logic             rd_pend;

    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic [2:0] occ;
    logic       pop;
    logic       in_hs;
    logic       rd_issue;
    logic       unused_rdata;

    // Streams transfer a byte on any cycle where valid && ready; valid never waits on ready.
    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_data;
    assign pop       = out_valid && out_ready;

    // A read is issued only if its byte will still fit after the reads already in flight,
    // crediting a pop this cycle so the FIFO can sustain one byte per cycle.
    assign occ      = {1'b0, fifo_count} + {2'b00, rd_pend};
    assign rd_issue = (state == S_READ_C) && ((occ < 3'd2) || ((occ == 3'd2) && pop));

    assign bus_re       = rd_issue;
    assign bus_we       = we_q;
    assign bus_addr     = rd_issue ? win_addr(BASE_C, idx) : wr_addr_q;
    assign bus_wdata    = wdata_q;
    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign error        = err_q;
    assign state_dbg    = state;
    assign unused_rdata = ^bus_rdata[31:8];

    acc_byte_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (bus_rdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            to_cnt    <= '0;
            wr_addr_q <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            rd_pend <= rd_issue;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state <= S_LOAD_A;
                        idx   <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (in_hs) begin
                        we_q      <= 1'b1;
                        wr_addr_q <= win_addr((state == S_LOAD_A) ? BASE_A : BASE_B, idx);
                        wdata_q   <= {24'h000000, in_data};
                        idx       <= idx + IDX_W'(1);
                        if (idx == IDX_MAX) begin
                            state <= (state == S_LOAD_A) ? S_LOAD_B : S_START;
                        end
                    end
                end
                S_START: begin
                    we_q      <= 1'b1;
                    wr_addr_q <= START_ADDR;
                    wdata_q   <= 32'd1;
                    to_cnt    <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (acc_done) begin
                        state <= S_READ_C;
                        idx   <= '0;
                    end else if (to_cnt == TO_MAX) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_READ_C: begin
                    if (rd_issue) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_MAX) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!rd_pend && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_loader.sv
// Self-checking bench for acc_loader: full jobs, backpressure, timeout and mid-job reset.
// A bridge model answers reads with C[i] = i ^ ckey.
module tb_acc_loader;
  import acc_pkg::*;

  localparam int TO = 100;
  localparam int M  = MAT_BYTES;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata = 32'd0;
  logic        acc_done;
  logic        busy;
  logic        error;
  logic [2:0]  state_dbg;

  acc_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .acc_done(acc_done), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared bench state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    string       name;
    int          kind;   // 0: bus write record, 1: output byte
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[10];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ckey = 8'h5A;
  logic       rnd_ready = 1'b0;
  logic       job_active = 1'b0;
  logic       start_seen = 1'b0;
  int start_cyc = 0;
  int first_ov_cyc = -1;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  int occ = 0;
  logic pend = 1'b0;
  int both_viol = 0, ov_viol = 0, flow_viol = 0, occ_viol = 0, cr_viol = 0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] a_byte(input int i, input logic [7:0] k);
    logic [7:0] b;
    b = i[7:0];
    return b ^ k;
  endfunction

  function automatic logic [7:0] b_byte(input int i, input logic [7:0] k);
    logic [7:0] b;
    b = i[7:0];
    return (~b) ^ k;
  endfunction

  function automatic logic [7:0] c_byte(input int i, input logic [7:0] k);
    logic [7:0] b;
    b = i[7:0];
    return b ^ k;
  endfunction

  // ---------------- bridge model: read data valid one cycle after bus_re ----------------
  logic [31:0] rd_off;
  always @(posedge clk) begin
    if (bus_re) begin
      rd_off = bus_addr - BASE_C;
      bus_rdata <= {24'hC0FFEE, rd_off[7:0] ^ ckey};
    end
  end

  // ---------------- output backpressure driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      occ  = 0;
      pend = 1'b0;
    end else begin
      if (bus_we && bus_re) both_viol++;
      if (bus_we) begin
        wr_q.push_back('{addr: bus_addr, data: bus_wdata, cyc: cyc});
        if (bus_addr == START_ADDR) begin
          start_seen = 1'b1;
          start_cyc  = cyc;
        end
      end
      if (out_valid !== (occ > 0)) ov_viol++;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (job_active && cmd_ready) cr_viol++;
      if (bus_re && (occ + int'(pend) + 1 - int'(out_valid && out_ready) > 2)) flow_viol++;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      occ = occ + int'(pend) - int'(out_valid && out_ready);
      if (occ > 2 || occ < 0) occ_viol++;
      pend = bus_re;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ctrl"}, {49'd0, cmd_ready, in_ready, out_valid, bus_we, bus_re, busy, error, out_data},
          {49'd0, 7'b1000000, 8'h00});
    check({name, "_bus"}, {bus_addr, bus_wdata}, 64'd0);
    check({name, "_state"}, 64'(state_dbg), 64'(S_IDLE));
  endtask

  task automatic set_vec(input int i, input string name, input int kind, input int idx,
                         input logic [31:0] addr, input logic [31:0] data);
    vecs[i].name = name;
    vecs[i].kind = kind;
    vecs[i].idx  = idx;
    vecs[i].addr = addr;
    vecs[i].data = data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input string name);
    int g;
    g = 0;
    while (!cmd_ready && g < 5000) begin
      @(posedge clk); #1; g++;
    end
    wr_q.delete();
    out_q.delete();
    start_seen    = 1'b0;
    first_ov_cyc  = -1;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
    cmd_valid = 1'b1;
    @(negedge clk);
    check({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    job_active = 1'b1;
  endtask

  task automatic stream(input int n, input int gaps, input int pulse_at,
                        input logic [7:0] akey, input logic [7:0] bkey);
    int j;
    int g;
    logic pulsed;
    j = 0;
    g = 0;
    pulsed = 1'b0;
    while (j < n && g < 20000) begin
      in_valid = (gaps == 0) || ($urandom_range(0, 3) != 0);
      in_data  = (j < M) ? a_byte(j, akey) : b_byte(j - M, bkey);
      cmd_valid = (j == pulse_at) && !pulsed;
      if (cmd_valid) pulsed = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) j++;
      @(posedge clk); #1;
      g++;
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    check("stream_done", 64'(j), 64'(n));
  endtask

  task automatic wait_start(input string name);
    int g;
    g = 0;
    while (!start_seen && g < 500) begin
      @(posedge clk); #1; g++;
    end
    check({name, "_start_seen"}, 64'(start_seen), 64'd1);
  endtask

  task automatic finish_job(input string name);
    int g;
    while (cyc < start_cyc + 10) begin
      @(posedge clk); #1;
    end
    acc_done = 1'b1;
    g = 0;
    while (out_q.size() < M && g < 20000) begin
      @(posedge clk); #1; g++;
    end
    check({name, "_out_count"}, 64'(out_q.size()), 64'(M));
    job_active = 1'b0;
    @(negedge clk);
    check({name, "_idle_after_pop"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    acc_done = 1'b0;
  endtask

  task automatic check_job(input string name, input logic [7:0] akey,
                           input logic [7:0] bkey, input logic [7:0] k);
    int bad;
    logic [31:0] ea;
    logic [31:0] ed;
    check({name, "_wr_count"}, 64'(wr_q.size()), 64'(2 * M + 1));
    bad = 0;
    for (int i = 0; i < wr_q.size() && i <= 2 * M; i++) begin
      if (i < M) begin
        ea = BASE_A + 32'(i); ed = {24'd0, a_byte(i, akey)};
      end else if (i < 2 * M) begin
        ea = BASE_B + 32'(i - M); ed = {24'd0, b_byte(i - M, bkey)};
      end else begin
        ea = START_ADDR; ed = 32'd1;
      end
      if (wr_q[i].addr !== ea || wr_q[i].data !== ed) bad++;
    end
    check({name, "_wr_seq"}, 64'(bad), 64'd0);
    exp_q.delete();
    for (int i = 0; i < M; i++) exp_q.push_back(c_byte(i, k));
    bad = 0;
    for (int i = 0; i < out_q.size() && exp_q.size() > 0; i++) begin
      if (out_q[i] !== exp_q.pop_front()) bad++;
    end
    check({name, "_out_seq"}, 64'(bad), 64'd0);
    check({name, "_error"}, 64'(error), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] ak;
    logic [7:0] bk;
    rst_n = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0; in_data = 8'h00; acc_done = 1'b0;

    set_vec(0, "wr_a0",    0, 0,     32'd1024, 32'h00);
    set_vec(1, "wr_a300",  0, 300,   32'd1324, 32'h2C);
    set_vec(2, "wr_a1023", 0, 1023,  32'd2047, 32'hFF);
    set_vec(3, "wr_b0",    0, 1024,  32'd2048, 32'hFF);
    set_vec(4, "wr_b1023", 0, 2047,  32'd3071, 32'h00);
    set_vec(5, "wr_start", 0, 2048,  32'd1023, 32'h01);
    set_vec(6, "out_0",    1, 0,     32'd0,    32'h5A);
    set_vec(7, "out_1",    1, 1,     32'd0,    32'h5B);
    set_vec(8, "out_255",  1, 255,   32'd0,    32'hA5);
    set_vec(9, "out_1023", 1, 1023,  32'd0,    32'hA5);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // job 1: full rate in and out
    @(posedge clk); #1;
    ckey = 8'h5A;
    start_cmd("job1");
    stream(2 * M, 0, -1, 8'h00, 8'h00);
    wait_start("job1");
    finish_job("job1");
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind == 0) begin
        check({vecs[i].name, "_addr"}, 64'(wr_q[vecs[i].idx].addr), 64'(vecs[i].addr));
        check({vecs[i].name, "_data"}, 64'(wr_q[vecs[i].idx].data), 64'(vecs[i].data));
      end else begin
        check(vecs[i].name, 64'(out_q[vecs[i].idx]), 64'(vecs[i].data));
      end
    end
    check_job("job1", 8'h00, 8'h00, 8'h5A);
    check("job1_load_span", 64'(wr_q[2 * M - 1].cyc - wr_q[0].cyc), 64'(2 * M - 1));
    check("job1_start_after_b", 64'(wr_q[2 * M].cyc - wr_q[2 * M - 1].cyc), 64'd1);
    check("job1_first_out_valid", 64'(first_ov_cyc), 64'(start_cyc + 13));
    check("job1_out_span", 64'(last_pop_cyc - first_pop_cyc), 64'(M - 1));

    // job 2: random gaps, random backpressure, stray cmd during LOAD_B
    ak = 8'($urandom_range(0, 255));
    bk = 8'($urandom_range(0, 255));
    ckey = 8'($urandom_range(0, 255));
    rnd_ready = 1'b1;
    start_cmd("job2");
    stream(2 * M, 1, M + 300, ak, bk);
    wait_start("job2");
    finish_job("job2");
    rnd_ready = 1'b0;
    check_job("job2", ak, bk, ckey);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("job2_cmd_ignored", {busy, 31'(wr_q.size())}, {1'b0, 31'(2 * M + 1)});

    // timeout: acc_done never rises
    @(posedge clk); #1;
    start_cmd("tmo");
    stream(2 * M, 0, -1, 8'h11, 8'h22);
    wait_start("tmo");
    while (cyc < start_cyc + 100) begin
      @(posedge clk); #1;
    end
    job_active = 1'b0;
    @(negedge clk);
    check("tmo_still_waiting", {busy, error}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_error_idle", {busy, error, cmd_ready}, 3'b011);

    // next command clears error; reset during A byte 500 aborts the job
    @(posedge clk); #1;
    start_cmd("clr");
    @(negedge clk);
    check("clr_error", 64'(error), 64'd0);
    @(posedge clk); #1;
    stream(500, 0, -1, 8'h00, 8'h00);
    job_active = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");

    // job 3: restart after reset
    @(posedge clk); #1;
    ak = 8'($urandom_range(0, 255));
    bk = 8'($urandom_range(0, 255));
    ckey = 8'($urandom_range(0, 255));
    start_cmd("job3");
    stream(2 * M, 1, -1, ak, bk);
    wait_start("job3");
    finish_job("job3");
    check("job3_first_addr", 64'(wr_q[0].addr), 64'(BASE_A));
    check_job("job3", ak, bk, ckey);

    check("we_re_overlap", 64'(both_viol), 64'd0);
    check("out_valid_vs_occupancy", 64'(ov_viol), 64'd0);
    check("read_issue_overflow", 64'(flow_viol), 64'd0);
    check("fifo_occupancy_range", 64'(occ_viol), 64'd0);
    check("cmd_ready_during_job", 64'(cr_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_loader.md
# acc_loader

Bus-initiator counterpart to the accelerator's memory-mapped data bridge. It accepts a command, streams 1024 bytes of matrix A and 1024 bytes of matrix B from a byte stream into the bridge's A/B windows, and writes the start address. It then waits for the accelerator's done flag and reads the 1024 result bytes of matrix C back out onto an output byte stream. It sits between a DMA/stream source and the accelerator bridge, replacing core-driven load/store loops.

## Interface
- MAT_BYTES, 1024: bytes per matrix; power of two.
- START_ADDR, 1023: bridge address whose write triggers the accelerator.
- BASE_A, 1024: bridge address of A[0].
- BASE_B, 2048: bridge address of B[0].
- BASE_C, 3072: bridge address of C[0].
- TIMEOUT, 65535: maximum WAIT cycles before error.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- cmd_valid  in  1  request a full load/run/readback job.
- cmd_ready  out  1  high only in IDLE.
- in_valid, in_ready  in/out  1  A-then-B byte stream handshake.
- in_data  in  8  matrix byte, row-major.
- out_valid, out_ready  out/in  1  C byte stream handshake.
- out_data  out  8  result byte, row-major.
- bus_addr  out  32  bridge address.
- bus_wdata  out  32  write data; byte in [7:0], upper bits zero.
- bus_we  out  1  one-cycle write strobe.
- bus_re  out  1  one-cycle read strobe.
- bus_rdata  in  32  read data, valid exactly one cycle after bus_re; only [7:0] used.
- acc_done  in  1  accelerator result ready, level.
- busy  out  1  state != IDLE.
- error  out  1  sticky timeout flag; cleared by the next accepted cmd or reset.

## Operation
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - State IDLE; index counter, timeout counter and FIFO cleared.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, READ_C, DRAIN.
- IDLE:
  - cmd_valid&&cmd_ready → LOAD_A, idx=0, error cleared.
  - in_ready=0, bus strobes 0.
- LOAD_A and LOAD_B:
  - in_ready=1.
  - Each in handshake registers a write: next cycle bus_we=1, bus_addr=BASE_A+idx (or BASE_B+idx), bus_wdata={24'b0,in_data}, then idx increments.
  - idx is log2(MAT_BYTES) bits and wraps MAT_BYTES-1→0 on the final handshake.
  - The wrap moves LOAD_A→LOAD_B, or LOAD_B→START.
  - Gaps in in_valid stall without penalty.
- START: one cycle with bus_we=1, bus_addr=START_ADDR, bus_wdata=1, then → WAIT with timeout counter=0.
- WAIT:
  - acc_done=1 sampled → READ_C, idx=0.
  - Otherwise the counter increments.
  - Counter==TIMEOUT with acc_done still 0 → error=1, → IDLE.
  - acc_done and counter==TIMEOUT in the same cycle: done wins.
- READ_C:
  - Issue bus_re, bus_addr=BASE_C+idx, whenever fifo_count + outstanding < 2 and idx has not wrapped.
  - bus_rdata[7:0] is pushed into the FIFO one cycle later.
  - Issuing the read for idx MAT_BYTES-1 → DRAIN.
- DRAIN: → IDLE when no read is outstanding and the FIFO is empty.
- The output stream is fed from FIFO head: out_valid = !empty; pop on out_valid&&out_ready.
- bus_we and bus_re are never high in the same cycle.
- in_ready is 0 outside the LOAD states.
- cmd_valid outside IDLE is ignored, not queued.
- Reset mid-job aborts immediately to IDLE. The bridge's start flag is not cleared by this block.

## Timing
- LOAD: peak rate 1 byte/cycle; bus write lags the in handshake by exactly 1 cycle.
- Minimum LOAD_A+LOAD_B time: 2·MAT_BYTES cycles; the last B write is on the cycle START is entered.
- START to WAIT: 1 cycle. acc_done is sampled from the first WAIT cycle.
- READ_C:
  - Read→FIFO latency: 1 cycle.
  - First out_valid: 2 cycles after entering READ_C.
  - Sustained 1 byte/cycle while out_ready=1.
- Backpressure: out_ready=0 for ≥2 cycles halts read issue after at most 2 bytes are buffered or outstanding. No byte is lost or duplicated.
- Job end: IDLE (cmd_ready=1) the cycle after the final pop.

## Structure
- Package acc_pkg:
  - state enum acc_ld_state_t;
  - address constants START_ADDR, BASE_A, BASE_B, BASE_C (shared with the bridge);
  - MAT_BYTES.
- Sub-module acc_byte_fifo: 2-entry, 8-bit, push/pop/count, with simultaneous push+pop allowed when full.
- Top holds the FSM, index/timeout counters, and registered bus outputs.

## Test plan
- Stream A[i]=i[7:0], B[i]=~i[7:0] with in_valid always 1.
  - Required: 2048 writes, A[0]@1024=0x00, B[1023]@3071=0x00, then one write @1023 data 1.
  - No missing or extra bus_we.
- acc_done rises 10 cycles into WAIT; bridge model returns C[i]=i^0x5A.
  - Required: 1024 out bytes in order, first 0x5A, last 0xA5.
  - First out_valid 2 cycles after READ_C entry.
- Random out_ready (50%) and random in_valid gaps.
  - Required: identical byte sequences, FIFO count never >2, no bus_re while count+outstanding==2.
- acc_done held 0 with TIMEOUT=100.
  - Required: error=1 and IDLE 101 cycles after WAIT entry.
  - Next cmd clears error.
- rst_n=0 for one cycle at A byte 500.
  - Required: all outputs at reset values the next cycle; a new cmd restarts at BASE_A+0.
- cmd_valid pulsed during LOAD_B.
  - Required: ignored, and cmd_ready stays 0 until job end.
